hilo_muldiv_unit: RTL and testbench

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/hilo_muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply / multiply-accumulate / divide unit with mthi/mtlo access.
// One shift-add or restoring shift-subtract step per cycle; fixed WIDTH-cycle latency.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             move_to_hi,
  input  logic             move_to_lo,
  input  logic [WIDTH-1:0] move_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MSUB  = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state, state_nxt;
  logic               start_ok, last_step;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [W2-1:0]      acc, acc_nxt, acc_mul, acc_div;
  logic [W2-1:0]      mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg_q, neg_r, zero_div;
  logic               is_div_q, mul_sub;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        if (start && (op <= OP_DIVU) && !move_to_hi && !move_to_lo) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          last_step = 1'b1;
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand conditioning at start: sign handling for signed ops
  always_comb begin
    sgn   = (op != OP_MULTU) && (op != OP_DIVU);
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration of the datapath; the signed multiplier MSB carries negative weight
  always_comb begin
    is_div_q = op_q[2];
    mul_sub  = (op_q == OP_MSUB) ^ ((op_q != OP_MULTU) && last_step);
    acc_mul  = acc;
    if (mplier[0]) acc_mul = mul_sub ? (acc - mcand) : (acc + mcand);

    shifted = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, mcand[WIDTH-1:0]};
    if (!diff[WIDTH]) acc_div = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else              acc_div = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    acc_nxt = is_div_q ? acc_div : acc_mul;

    if (!is_div_q) begin
      {res_hi, res_lo} = acc_nxt;
    end else if (zero_div) begin
      res_hi = mplier;
      res_lo = '1;
    end else begin
      res_lo = neg_q ? -acc_nxt[WIDTH-1:0]  : acc_nxt[WIDTH-1:0];
      res_hi = neg_r ? -acc_nxt[W2-1:WIDTH] : acc_nxt[W2-1:WIDTH];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      op_q        <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
    end else begin
      busy        <= (state_nxt == RUN);
      done        <= last_step;
      div_by_zero <= last_step & is_div_q & zero_div;

      if (state == IDLE) begin
        if (move_to_hi) hi <= move_data;
        if (move_to_lo) lo <= move_data;
      end

      if (start_ok) begin
        op_q <= op;
        cnt  <= CNT_W'(WIDTH - 1);
        if (op[2]) begin
          mcand    <= {{WIDTH{1'b0}}, b_mag};
          acc      <= {{WIDTH{1'b0}}, a_mag};
          mplier   <= a;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          zero_div <= (b == '0);
        end else begin
          mcand    <= {{WIDTH{a[WIDTH-1] & sgn}}, a};
          mplier   <= b;
          acc      <= ((op == OP_MADD) || (op == OP_MSUB)) ? {hi, lo} : '0;
          neg_q    <= 1'b0;
          neg_r    <= 1'b0;
          zero_div <= 1'b0;
        end
      end

      if (state == RUN) begin
        acc <= acc_nxt;
        if (!is_div_q) begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        if (!last_step) cnt <= cnt - CNT_W'(1);
      end

      if (last_step) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: arithmetic reference model with per-cycle compare
// plus hand-computed expectations for the directed cases.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, move_to_hi, move_to_lo;
  logic [2:0]  op;
  logic [31:0] a, b, move_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .move_to_hi(move_to_hi), .move_to_lo(move_to_lo), .move_data(move_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference result of one operation from plain integer arithmetic
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] hl,
                                            output logic dz);
    longint sx, sy, ux, uy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    dz = 1'b0;
    res = '0;
    case (o)
      3'd0: res = sx * sy;
      3'd1: res = ux * uy;
      3'd2: res = hl + sx * sy;
      3'd3: res = hl - sx * sy;
      3'd4, 3'd5: begin
        if (y == 32'd0) begin
          dz = 1'b1;
          res = {x, 32'hFFFF_FFFF};
        end else begin
          q = (o == 3'd4) ? sx / sy : ux / uy;
          r = (o == 3'd4) ? sx % sy : ux % uy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = hl;
    endcase
    return res;
  endfunction

  // Cycle-level behavioural model
  logic        m_busy = 0, m_done = 0, m_dbz = 0, m_dz_p = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_pend = 0;
  int          m_left = 0;
  int          m_phase = 0;  // 0 idle, 1 computing, 2 result cycle
  bit          chk_en = 0;

  always @(posedge clk) begin
    m_done = 0;
    m_dbz  = 0;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_phase = 0;
    end else begin
      case (m_phase)
        0: begin
          if (move_to_hi || move_to_lo) begin
            if (move_to_hi) m_hi = move_data;
            if (move_to_lo) m_lo = move_data;
          end else if (start && op <= 3'd5) begin
            m_pend  = model_res(op, a, b, {m_hi, m_lo}, m_dz_p);
            m_left  = 32;
            m_busy  = 1;
            m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            {m_hi, m_lo} = m_pend;
            m_busy  = 0;
            m_done  = 1;
            m_dbz   = m_dz_p;
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 5;
      if (busy !== m_busy) begin errors++; $display("FAIL busy t=%0t got %b want %b", $time, busy, m_busy); end
      if (done !== m_done) begin errors++; $display("FAIL done t=%0t got %b want %b", $time, done, m_done); end
      if (div_by_zero !== m_dbz) begin errors++; $display("FAIL dbz t=%0t got %b want %b", $time, div_by_zero, m_dbz); end
      if (hi !== m_hi) begin errors++; $display("FAIL hi t=%0t got %h want %h", $time, hi, m_hi); end
      if (lo !== m_lo) begin errors++; $display("FAIL lo t=%0t got %h want %h", $time, lo, m_lo); end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic clear_inputs();
    start = 0; move_to_hi = 0; move_to_lo = 0; op = 0; a = 0; b = 0; move_data = 0;
  endtask

  // Issue an op, scramble operands afterwards, wait for done; returns cycles to done
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic dz_seen);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom;
    lat = 0;
    dz_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin lat = i; dz_seen = div_by_zero; break; end
    end
    if (lat == 0) begin
      errors++;
      $display("FAIL timeout op=%0d got no done want done", o);
    end
  endtask

  task automatic move(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    move_to_hi = h; move_to_lo = l; move_data = d;
    @(negedge clk);
    move_to_hi = 0; move_to_lo = 0;
  endtask

  int   lat;
  logic dz;

  initial begin
    clear_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 0;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat, dz);
    chk("mult_lat", lat, 32);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    move(1, 1, 32'd0);
    move(0, 1, 32'd10);
    run_op(3'd2, 32'd3, 32'd4, lat, dz);
    chk("madd_hi", hi, 32'd0);
    chk("madd_lo", lo, 32'd22);
    run_op(3'd3, 32'd2, 32'd20, lat, dz);
    chk("msub_hi", hi, 32'hFFFF_FFFF);
    chk("msub_lo", lo, 32'hFFFF_FFEE);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, lat, dz);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd7, 32'd0, lat, dz);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd7);
    chk("divu0_dbz", {31'd0, dz}, 32'd1);
    chk("divu0_lat", lat, 32);

    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, dz);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_dbz", {31'd0, dz}, 32'd0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, dz);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    run_op(3'd5, 32'd100, 32'd7, lat, dz);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, lat, dz);
    chk("divneg_lo", lo, 32'hFFFF_FFFD);
    chk("divneg_hi", hi, 32'd1);
    run_op(3'd4, 32'hFFFF_FFF0, 32'd0, lat, dz);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'hFFFF_FFF0);
    chk("div0_dbz", {31'd0, dz}, 32'd1);

    // In-flight MULTU: start/move ignored, then reset aborts it
    @(negedge clk);
    start = 1; op = 3'd1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    start = 1; move_to_lo = 1; move_data = 32'hDEAD_BEEF; op = 3'd0;
    @(negedge clk);
    start = 0; move_to_lo = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    reset = 0;
    start = 1; op = 3'd0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 0;
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    repeat (35) @(negedge clk);
    chk("post_rst_lo", lo, 32'd42);

    // Start together with a move: only the move happens
    @(negedge clk);
    start = 1; op = 3'd0; a = 32'd3; b = 32'd3; move_to_hi = 1; move_data = 32'h1234;
    @(negedge clk);
    start = 0; move_to_hi = 0;
    chk("mv_hi", hi, 32'h1234);
    chk("mv_busy", {31'd0, busy}, 32'd0);

    // Reserved opcode is ignored
    @(negedge clk);
    start = 1; op = 3'd6;
    @(negedge clk);
    start = 0;
    chk("rsv_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
